// File: rtl/i2c_reg_sched_if.sv
// i2c_reg_sched_if: request/done bus between the register-read scheduler and the shared i2c core.
interface i2c_reg_sched_if #(
    parameter int ADDR_W = 7,
    parameter int DAT_W  = 8
);
    logic              i2c_req;
    logic              i2c_done;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DAT_W-1:0]  i2c_dat_to_slv;
    logic [DAT_W-1:0]  i2c_dat_from_slv;
    modport master (output i2c_req, i2c_addr, i2c_dat_to_slv, input i2c_done, i2c_dat_from_slv);
    modport slave  (input i2c_req, i2c_addr, i2c_dat_to_slv, output i2c_done, i2c_dat_from_slv);
endinterface

// File: rtl/i2c_reg_sched.sv
// i2c_reg_sched: round-robin scheduler sharing one i2c core among register-read clients,
// with a per-transaction watchdog and a settle period after reset or abort.
module i2c_reg_sched #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ADDR_W      = 7,
    parameter int DAT_W       = 8,
    localparam int GW = $clog2(NUM_REQ),
    localparam int WW = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                      clk_200k,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_cl_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_cl_addr,
    input  logic [NUM_REQ*DAT_W-1:0]  i_cl_reg,
    output logic [NUM_REQ-1:0]        o_cl_done,
    output logic                      o_cl_err,
    output logic [DAT_W-1:0]          o_cl_data,
    output logic                      o_busy,
    output logic [GW-1:0]             o_gnt_id,
    i2c_reg_sched_if.master           bus
);
    typedef enum logic [1:0] {SETTLE, IDLE, BUSY, DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [WW-1:0]      r_wdog;
    logic [GW-1:0]      r_rr_ptr, r_gnt_id, w_gnt, w_next_ptr;
    logic [NUM_REQ-1:0] r_cl_done;
    logic               r_cl_err, r_i2c_req, w_grant, w_ok, w_to;
    logic [DAT_W-1:0]   r_cl_data, r_i2c_dat;
    logic [ADDR_W-1:0]  r_i2c_addr;

    function automatic logic [GW-1:0] wrap(input int v);
        return GW'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction

    // Descending scan so the nearest requester at or after rr_ptr wins.
    always_comb begin
        w_gnt = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (i_cl_req[wrap(int'(r_rr_ptr) + k)]) w_gnt = wrap(int'(r_rr_ptr) + k);
        w_grant     = r_state == IDLE && |i_cl_req && !bus.i2c_done;
        w_ok        = r_state == BUSY && bus.i2c_done;
        w_to        = r_state == BUSY && !bus.i2c_done && r_wdog == WW'(1);
        w_next_ptr  = wrap(int'(r_gnt_id) + 1);
        w_state_nxt = (r_state == SETTLE && r_wdog <= WW'(1)) ? IDLE :
                      w_grant ? BUSY :
                      w_ok ? DRAIN :
                      w_to ? SETTLE :
                      (r_state == DRAIN && !bus.i2c_done) ? IDLE : r_state;
    end

    always_ff @(posedge clk_200k) begin
        if (rst) begin
            r_state    <= SETTLE;
            r_wdog     <= WW'(TIMEOUT_CYC);
            r_rr_ptr   <= '0;
            r_gnt_id   <= '0;
            r_cl_done  <= '0;
            r_cl_err   <= 1'b0;
            r_cl_data  <= '0;
            r_i2c_req  <= 1'b0;
            r_i2c_addr <= '0;
            r_i2c_dat  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wdog    <= (w_grant || w_to) ? WW'(TIMEOUT_CYC) :
                         (r_wdog != '0 && (r_state == SETTLE || r_state == BUSY)) ? r_wdog - 1'b1 : r_wdog;
            r_cl_done <= (w_ok || w_to) ? NUM_REQ'(1) << r_gnt_id : '0;
            r_cl_err  <= w_to;
            if (w_grant) begin
                r_gnt_id   <= w_gnt;
                r_i2c_addr <= i_cl_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
                r_i2c_dat  <= i_cl_reg[int'(w_gnt)*DAT_W +: DAT_W];
                r_i2c_req  <= 1'b1;
            end
            if (w_ok || w_to) begin
                r_cl_data <= w_to ? '1 : bus.i2c_dat_from_slv;
                r_i2c_req <= 1'b0;
                r_rr_ptr  <= w_next_ptr;
            end
        end
    end

    assign o_cl_done          = r_cl_done;
    assign o_cl_err           = r_cl_err;
    assign o_cl_data          = r_cl_data;
    assign o_busy             = r_state != IDLE;
    assign o_gnt_id           = r_gnt_id;
    assign bus.i2c_req        = r_i2c_req;
    assign bus.i2c_addr       = r_i2c_addr;
    assign bus.i2c_dat_to_slv = r_i2c_dat;
endmodule

// File: tb/tb_i2c_reg_sched.sv
// tb_i2c_reg_sched: directed scenarios against a small i2c core model with a bus/client monitor.
module tb_i2c_reg_sched;
    localparam int N = 4, T = 64, AW = 7, DW = 8;

    logic clk_200k = 1'b0, rst = 1'b0;
    always #5 clk_200k = ~clk_200k;

    logic [N-1:0]    cl_req = '0;
    logic [N*AW-1:0] cl_addr = {7'h4A, 7'h49, 7'h48, 7'h47};
    logic [N*DW-1:0] cl_reg  = {8'h30, 8'h20, 8'h00, 8'h10};
    logic [N-1:0]    cl_done;
    logic            cl_err, busy;
    logic [DW-1:0]   cl_data;
    logic [1:0]      gnt_id;
    logic [DW-1:0]   exp_dat [4] = '{8'h45, 8'h5A, 8'h7B, 8'h68};

    i2c_reg_sched_if #(.ADDR_W(AW), .DAT_W(DW)) bus();

    i2c_reg_sched #(.NUM_REQ(N), .TIMEOUT_CYC(T), .ADDR_W(AW), .DAT_W(DW)) dut (
        .clk_200k(clk_200k), .rst(rst), .i_cl_req(cl_req), .i_cl_addr(cl_addr), .i_cl_reg(cl_reg),
        .o_cl_done(cl_done), .o_cl_err(cl_err), .o_cl_data(cl_data), .o_busy(busy),
        .o_gnt_id(gnt_id), .bus(bus)
    );

    // Core model: no reset, done after lat cycles, held for hold_len cycles.
    logic          core_done = 1'b0;
    logic [DW-1:0] core_dat  = '0;
    bit            hang = 0;
    int            lat = 3, hold_len = 1, lat_cnt = 0, hold_cnt = 0;
    assign bus.i2c_done         = core_done;
    assign bus.i2c_dat_from_slv = core_dat;
    always @(posedge clk_200k) begin
        if (hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) core_done <= 1'b0;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                core_done <= 1'b1;
                core_dat  <= {1'b0, bus.i2c_addr} ^ bus.i2c_dat_to_slv ^ 8'h12;
                hold_cnt  <= hold_len;
            end
        end else if (bus.i2c_req && !hang) lat_cnt <= lat;
    end

    int            grants[$];
    logic [N-1:0]  done_q[$];
    logic [DW-1:0] data_q[$];
    logic          err_q[$];
    logic [AW-1:0] gaddr_q[$];
    logic [DW-1:0] greg_q[$];
    int unstable = 0, done_bad = 0, relaunch = 0, gap_bad = 0, hi_run = 0, lo_run = 0, hi_at_done = 0;
    bit auto_clr = 1;
    logic prev_req = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_dat = '0;

    always @(negedge clk_200k) begin
        if (bus.i2c_req && prev_req && (bus.i2c_addr !== prev_addr || bus.i2c_dat_to_slv !== prev_dat)) unstable++;
        if (bus.i2c_req && !prev_req) begin
            grants.push_back(int'(gnt_id));
            gaddr_q.push_back(bus.i2c_addr);
            greg_q.push_back(bus.i2c_dat_to_slv);
            if (prev_done) relaunch++;
            if (lo_run < 1) gap_bad++;
        end
        if (|cl_done) begin
            done_q.push_back(cl_done);
            data_q.push_back(cl_data);
            err_q.push_back(cl_err);
            hi_at_done = hi_run;
            if (cl_done !== (N'(1) << gnt_id) || (bus.i2c_req && !prev_req)) done_bad++;
            if (auto_clr) cl_req = cl_req & ~cl_done;
        end else if (cl_err !== 1'b0) done_bad++;
        hi_run    = bus.i2c_req ? hi_run + 1 : 0;
        lo_run    = bus.i2c_req ? 0 : lo_run + 1;
        prev_req  = bus.i2c_req;
        prev_done = bus.i2c_done;
        prev_addr = bus.i2c_addr;
        prev_dat  = bus.i2c_dat_to_slv;
    end

    int errors = 0, checks = 0;

    task automatic step();
        @(negedge clk_200k);
        #1;
    endtask

    task automatic clear_mon();
        grants.delete(); done_q.delete(); data_q.delete(); err_q.delete(); gaddr_q.delete(); greg_q.delete();
        unstable = 0; done_bad = 0; relaunch = 0; gap_bad = 0;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin step(); ok = |cl_done; end
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin step(); ok = bus.i2c_req; end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = !busy;
        for (int i = 0; i < bound && !ok; i++) begin step(); ok = !busy; end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (bus.i2c_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.i2c_req); end
        checks++; if (cl_done !== '0) begin errors++; $display("FAIL reset_done got %b exp 0", cl_done); end
        checks++; if (cl_err !== 1'b0 || cl_data !== 8'h00) begin errors++; $display("FAIL reset_err_data got %b/%h exp 0/00", cl_err, cl_data); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d exp 0", gnt_id); end
        checks++; if (bus.i2c_addr !== '0 || bus.i2c_dat_to_slv !== '0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", bus.i2c_addr, bus.i2c_dat_to_slv); end
        n = 0;
        for (int i = 0; i < T; i++) begin if (busy && !bus.i2c_req) n++; step(); end
        checks++; if (n !== T) begin errors++; $display("FAIL reset_settle got %0d exp %0d", n, T); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        cl_req = 4'b0010;
        step();
        checks++; if (bus.i2c_req !== 1'b1 || gnt_id !== 2'd1) begin errors++; $display("FAIL single_launch req/gnt got %b/%0d exp 1/1", bus.i2c_req, gnt_id); end
        wait_done(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done_wait got timeout exp done"); end
        checks++; if (cl_done !== 4'b0010 || cl_data !== 8'h5A || cl_err !== 1'b0) begin errors++; $display("FAIL single_result got %b/%h/%b exp 0010/5a/0", cl_done, cl_data, cl_err); end
        repeat (6) step();
        checks++; if (done_q.size() !== 1 || grants.size() !== 1) begin errors++; $display("FAIL single_counts got %0d dones %0d grants exp 1/1", done_q.size(), grants.size()); end
        checks++; if (gaddr_q[0] !== 7'h48 || greg_q[0] !== 8'h00) begin errors++; $display("FAIL single_bus got %h/%h exp 48/00", gaddr_q[0], greg_q[0]); end
        checks++; if (unstable !== 0 || done_bad !== 0) begin errors++; $display("FAIL single_stable got %0d unstable %0d bad exp 0/0", unstable, done_bad); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        wait_idle(T + 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle_wait got timeout exp idle"); end
        clear_mon();
        hold_len = 3;
        cl_req = 4'b1111;
        for (int i = 0; i < 300 && done_q.size() < 4; i++) step();
        repeat (6) step();
        hold_len = 1;
        checks++; if (grants.size() !== 4 || done_q.size() !== 4) begin errors++; $display("FAIL b2b_counts got %0d grants %0d dones exp 4/4", grants.size(), done_q.size()); end
        for (int i = 0; i < 4 && i < grants.size() && i < done_q.size(); i++) begin
            checks++; if (grants[i] !== i) begin errors++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, grants[i], i); end
            checks++; if (done_q[i] !== (4'b0001 << i) || data_q[i] !== exp_dat[i] || err_q[i] !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d] got %b/%h/%b exp %b/%h/0", i, done_q[i], data_q[i], err_q[i], 4'b0001 << i, exp_dat[i]); end
        end
        checks++; if (relaunch !== 0 || gap_bad !== 0) begin errors++; $display("FAIL b2b_gap got relaunch %0d gap %0d exp 0/0", relaunch, gap_bad); end
        checks++; if (done_bad !== 0 || unstable !== 0 || cl_req !== '0) begin errors++; $display("FAIL b2b_clean got bad %0d unstable %0d req %b exp 0/0/0000", done_bad, unstable, cl_req); end
    endtask

    task automatic test_rr_pair();
        int exp_g [5] = '{0, 2, 0, 2, 0};
        clear_mon();
        auto_clr = 0;
        cl_req = 4'b0101;
        for (int i = 0; i < 300 && done_q.size() < 5; i++) step();
        cl_req = '0;
        auto_clr = 1;
        repeat (6) step();
        checks++; if (grants.size() !== 5) begin errors++; $display("FAIL rr_count got %0d exp 5", grants.size()); end
        for (int i = 0; i < 5 && i < grants.size() && i < data_q.size(); i++) begin
            checks++; if (grants[i] !== exp_g[i] || data_q[i] !== exp_dat[exp_g[i]]) begin errors++; $display("FAIL rr_grant[%0d] got %0d/%h exp %0d/%h", i, grants[i], data_q[i], exp_g[i], exp_dat[exp_g[i]]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        wait_idle(20, ok);
        clear_mon();
        hang = 1;
        cl_req = 4'b0010;
        wait_done(T + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_wait got timeout exp done"); end
        checks++; if (cl_done !== 4'b0010 || cl_err !== 1'b1 || cl_data !== 8'hFF) begin errors++; $display("FAIL to_result got %b/%b/%h exp 0010/1/ff", cl_done, cl_err, cl_data); end
        checks++; if (hi_at_done !== T) begin errors++; $display("FAIL to_busy_len got %0d exp %0d", hi_at_done, T); end
        n = 0;
        for (int i = 0; i < T; i++) begin if (busy && !bus.i2c_req) n++; step(); end
        checks++; if (n !== T || busy !== 1'b0) begin errors++; $display("FAIL to_settle got %0d cycles busy %b exp %0d/0", n, busy, T); end
        checks++; if (done_q.size() !== 1 || done_bad !== 0) begin errors++; $display("FAIL to_single got %0d dones %0d bad exp 1/0", done_q.size(), done_bad); end
        hang = 0;
    endtask

    task automatic test_reset_busy();
        bit ok;
        int n;
        wait_idle(20, ok);
        clear_mon();
        lat = 10;
        cl_req = 4'b0001;
        wait_req(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rb_launch got no req exp req"); end
        step(); step();
        do_reset();
        n = 0;
        for (int i = 0; i < T; i++) begin if (busy && !bus.i2c_req) n++; step(); end
        checks++; if (n !== T) begin errors++; $display("FAIL rb_settle got %0d exp %0d", n, T); end
        checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL rb_no_done got %0d exp 0", done_q.size()); end
        wait_done(60, ok);
        checks++; if (!ok || cl_done !== 4'b0001 || cl_data !== 8'h45 || cl_err !== 1'b0) begin errors++; $display("FAIL rb_resume got %b/%h/%b exp 0001/45/0", cl_done, cl_data, cl_err); end
        lat = 3;
    endtask

    task automatic test_withdraw();
        bit ok;
        wait_idle(30, ok);
        clear_mon();
        cl_req = 4'b0001;
        wait_req(10, ok);
        cl_req[3] = 1'b1;
        step(); step();
        cl_req[3] = 1'b0;
        wait_done(40, ok);
        checks++; if (!ok || cl_done !== 4'b0001) begin errors++; $display("FAIL wd_done got %b exp 0001", cl_done); end
        repeat (12) step();
        checks++; if (grants.size() !== 1 || done_q.size() !== 1 || busy !== 1'b0) begin errors++; $display("FAIL wd_withdrawn got %0d grants %0d dones busy %b exp 1/1/0", grants.size(), done_q.size(), busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got hang exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rr_pair();
        test_timeout();
        test_reset_busy();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_reg_sched.md
Name: i2c_reg_sched

Overview:
- Round-robin scheduler sharing one `i2c` core between NUM_REQ register-read clients (sensors, dispenser status, etc.).
- Each client asks for "read register R of slave A". The scheduler drives the core's req/addr/dat_to_slv, waits for done, and returns the byte to that client only.
- Adds a per-transaction watchdog and a post-reset settle period, because the core itself has no reset.
- Runs in the core's clk_200k domain.

Parameters:
- NUM_REQ, 4, number of client ports (2..8).
- TIMEOUT_CYC, 1024, clk_200k cycles from launch to abort if core done is not seen.
- ADDR_W, 7, slave address width.
- DAT_W, 8, register pointer and data width.

Ports:
- clk_200k  in  1  system clock for this block; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cl_req  in  NUM_REQ  per-client level request; held until matching cl_done.
- cl_addr  in  NUM_REQ*ADDR_W  per-client slave address, slice i = client i.
- cl_reg  in  NUM_REQ*DAT_W  per-client register pointer.
- cl_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- cl_err  out  1  valid with cl_done; 1 = watchdog abort.
- cl_data  out  DAT_W  read byte, valid with cl_done, held until next completion.
- busy  out  1  high in any state except IDLE.
- gnt_id  out  $clog2(NUM_REQ)  index of the client being served; holds its last value when idle.
- i2c_req  out  1  to core req.
- i2c_done  in  1  from core done.
- i2c_addr  out  ADDR_W  to core addr.
- i2c_dat_to_slv  out  DAT_W  to core dat_to_slv.
- i2c_dat_from_slv  in  DAT_W  from core dat_from_slv.

Behaviour:
- Reset values: i2c_req=0, cl_done=0, cl_err=0, cl_data=0, gnt_id=0, i2c_addr=0, i2c_dat_to_slv=0, rr_ptr=0, busy=1, state=SETTLE, wdog loaded with TIMEOUT_CYC.
- SETTLE: i2c_req=0 while wdog counts down to 0. This lets any core transaction in flight at reset finish. Then go to IDLE.
- IDLE: if any cl_req bit is set and i2c_done==0, grant the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - On grant, latch gnt_id, i2c_addr=cl_addr[gnt], i2c_dat_to_slv=cl_reg[gnt].
  - On grant, set i2c_req=1, reload wdog, go to BUSY. Latency from cl_req seen in IDLE to i2c_req high is 1 cycle.
- BUSY: i2c_req, i2c_addr and i2c_dat_to_slv are held stable.
  - If i2c_done==1: capture cl_data=i2c_dat_from_slv, cl_err=0, pulse cl_done[gnt_id]. Also drop i2c_req, set rr_ptr=gnt_id+1 mod NUM_REQ, go to DRAIN.
  - Else if wdog reaches 0: set cl_data=all-ones, cl_err=1, pulse cl_done[gnt_id]. Also drop i2c_req, advance rr_ptr, reload wdog, go to SETTLE.
- DRAIN: i2c_req=0; wait for i2c_done==0, then go to IDLE. This prevents one done pulse being counted twice.
- A client dropping cl_req after grant has no effect; its transaction completes and it still gets cl_done.
- Dropping cl_req before grant withdraws the request.
- Simultaneous requests: strict round-robin, so no client is served twice while another requester waits.
- Reset mid-BUSY: i2c_req drops in the reset cycle, no cl_done is issued, and the block re-enters SETTLE.
- cl_done is never asserted for a client other than gnt_id, and never in the same cycle as i2c_req rising.
- cl_err is 0 whenever cl_done is all-zero.
- The core is never relaunched while i2c_done=1.

Test Plan:
- Single read, with a core model returning 0x5A for client 1 (addr 0x48, reg 0x00):
  - i2c_addr=0x48 and i2c_dat_to_slv=0x00 are held stable while i2c_req=1.
  - cl_done=0b0010 pulses once with cl_data=0x5A and cl_err=0.
- All four cl_req set at once after reset:
  - Grant order is 0,1,2,3.
  - Each client gets exactly one cl_done.
  - i2c_req is low for at least 1 cycle between transactions and stays low until i2c_done=0.
- Clients 0 and 2 held continuously after serving 0:
  - Grants alternate 2,0,2,0; neither client is starved.
- Core model never asserts done, with TIMEOUT_CYC=64:
  - After 64 cycles in BUSY, cl_done pulses for the granted client with cl_err=1 and cl_data=0xFF.
  - The block then spends 64 cycles in SETTLE with i2c_req=0.
- rst pulsed mid-BUSY while the core model later pulses done:
  - No cl_done is issued.
  - busy=1 and i2c_req=0 for TIMEOUT_CYC cycles, then normal service resumes.
- cl_req[3] pulsed high and low while client 0 is BUSY:
  - Client 3 is never granted and gets no cl_done.
